// File: rtl/i2c_master_wr.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | i2c_master_wr : single-byte I2C write master (START, addr+W, data,    |
// |                 STOP) with open-drain line enables and NACK report.   |
// | Revision      : 1.0                                                   |
// +-----------------------------------------------------------------------+

module i2c_master_wr #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_in,
  input  logic [6:0] addr_in,
  input  logic [7:0] data_in,
  input  logic       sda_in,
  output logic       scl_oe_out,
  output logic       sda_oe_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       nack_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_ACK1  = 3'd3,
    S_DATA  = 3'd4,
    S_ACK2  = 3'd5,
    S_STOP  = 3'd6
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state, state_nxt;
  logic [1:0] qtr, qtr_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [7:0] div_cnt;
  logic [7:0] shift_reg, shift_nxt;
  logic [7:0] data_reg;
  logic       nack_flag, nack_flag_nxt;
  logic       done_nxt;
  logic       scl_nxt, sda_nxt;
  logic       tick;
  logic       accept;

  assign tick   = (state != S_IDLE) && (div_cnt == DIV_LAST);
  assign accept = (state == S_IDLE) && start_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      qtr        <= 2'd0;
      bit_cnt    <= 3'd0;
      div_cnt    <= 8'd0;
      shift_reg  <= 8'd0;
      data_reg   <= 8'd0;
      nack_flag  <= 1'b0;
      scl_oe_out <= 1'b0;
      sda_oe_out <= 1'b0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
      nack_out   <= 1'b0;
    end else begin
      state      <= state_nxt;
      qtr        <= qtr_nxt;
      bit_cnt    <= bit_nxt;
      shift_reg  <= shift_nxt;
      nack_flag  <= nack_flag_nxt;
      div_cnt    <= (state == S_IDLE || tick) ? 8'd0 : div_cnt + 8'd1;
      scl_oe_out <= scl_nxt;
      sda_oe_out <= sda_nxt;
      busy_out   <= (state_nxt != S_IDLE);
      done_out   <= done_nxt;
      if (accept) begin
        data_reg <= data_in;
        nack_out <= 1'b0;
      end else if (done_nxt) begin
        nack_out <= nack_flag;
      end
    end
  end

  // Sequencing advances one quarter per tick; slot-level decisions happen at Q3.
  always_comb begin
    state_nxt     = state;
    qtr_nxt       = qtr;
    bit_nxt       = bit_cnt;
    shift_nxt     = shift_reg;
    nack_flag_nxt = nack_flag;
    done_nxt      = 1'b0;
    if (state == S_IDLE) begin
      if (start_in) begin
        state_nxt     = S_START;
        qtr_nxt       = 2'd0;
        bit_nxt       = 3'd0;
        shift_nxt     = {addr_in, 1'b0};
        nack_flag_nxt = 1'b0;
      end
    end else if (tick) begin
      qtr_nxt = qtr + 2'd1;
      if ((state == S_ACK1 || state == S_ACK2) && qtr == 2'd2 && sda_in == 1'b1) begin
        nack_flag_nxt = 1'b1;
      end
      if (qtr == 2'd3) begin
        case (state)
          S_START: begin
            state_nxt = S_ADDR;
            bit_nxt   = 3'd0;
          end
          S_ADDR, S_DATA: begin
            shift_nxt = {shift_reg[6:0], 1'b0};
            bit_nxt   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_nxt = (state == S_ADDR) ? S_ACK1 : S_ACK2;
            end
          end
          S_ACK1: begin
            if (nack_flag) begin
              state_nxt = S_STOP;
            end else begin
              state_nxt = S_DATA;
              shift_nxt = data_reg;
              bit_nxt   = 3'd0;
            end
          end
          S_ACK2: state_nxt = S_STOP;
          S_STOP: begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Line drive is decoded from the upcoming state so the enables are registered.
  always_comb begin
    scl_nxt = 1'b0;
    sda_nxt = 1'b0;
    case (state_nxt)
      S_START: begin
        scl_nxt = qtr_nxt[1];
        sda_nxt = (qtr_nxt != 2'd0);
      end
      S_ADDR, S_DATA: begin
        scl_nxt = !qtr_nxt[1];
        sda_nxt = !shift_nxt[7];
      end
      S_ACK1, S_ACK2: begin
        scl_nxt = !qtr_nxt[1];
      end
      S_STOP: begin
        scl_nxt = (qtr_nxt == 2'd0);
        sda_nxt = !qtr_nxt[1];
      end
      default: begin
        scl_nxt = 1'b0;
        sda_nxt = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire
